uart_block_packer: RTL and testbench
====================================

# uart_block_packer

Upstream stage of the AES-over-UART datapath. Collects the byte stream from the UART receiver into a 128-bit plaintext block (first byte received → MSB). Presents that block to the AES encrypt stage under a valid/ready handshake. Holds each block stable until it is consumed, flags bytes dropped while a block is pending, and optionally aborts stale partial blocks after an inter-byte idle timeout.

## Interface
Parameters:
- `BLOCK_BYTES`, 16: bytes per block; block width is `8*BLOCK_BYTES`.
- `TIMEOUT_CYCLES`, 1_000_000: idle cycles after which a partial block is discarded (used only with `PACKER_TIMEOUT_EN`); must be ≥ 2.

Ports:
- `clk`, in, 1: single clock; all logic rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx_data`, in, 8: received byte from the UART RX.
- `rx_valid`, in, 1: one-cycle strobe; `rx_data` valid this cycle.
- `block_out`, out, 128: assembled plaintext; meaningful only while `block_valid`=1.
- `block_valid`, out, 1: a complete block is held for the AES stage.
- `block_ready`, in, 1: AES stage accepts the block this cycle.
- `byte_count`, out, 5: bytes collected in the current block (0..16).
- `overrun`, out, 1: one-cycle pulse; a byte was dropped.
- `timeout_err`, out, 1: one-cycle pulse; partial block discarded by timeout (constant 0 without `PACKER_TIMEOUT_EN`).

## Operation
- States: FILL, HOLD. Reset → FILL; `block_out`=0, `block_valid`=0, `byte_count`=0, `overrun`=0, `timeout_err`=0, idle counter 0.
- FILL, `rx_valid`=1: `block_out` ← {`block_out`[119:0], `rx_data`}; `byte_count`++. If this is byte 16, go to HOLD, set `block_valid`=1, `byte_count`=16.
- HOLD: `block_out` frozen. When `block_valid`&&`block_ready` at an edge → FILL, `block_valid`=0, `byte_count`=0.
- HOLD, `rx_valid`=1 without `block_ready`: byte dropped, `overrun` pulses for one cycle, block unchanged.
- HOLD, `rx_valid` and `block_ready` in the same cycle: handshake completes and the byte is taken as byte 0 of the next block (`byte_count`=1). There is no overrun.
- `block_ready` is ignored in FILL.
- Reset mid-fill or mid-HOLD: partial/held block is discarded and all outputs take their reset values immediately (asynchronous).

## Timing
- 16th byte strobe sampled at edge N → `block_valid`=1 from edge N onward. Zero added cycles.
- Handshake completes at the edge where `block_valid`&&`block_ready`. `block_valid` is low from that edge.
- Throughput: one block per 16 byte strobes. HOLD may last indefinitely.
- `overrun`/`timeout_err` are registered, high exactly one cycle after the causing edge.

## Configuration
- `PACKER_TIMEOUT_EN` defined:
  - In FILL with `byte_count`>0, the idle counter increments each cycle without `rx_valid` and clears on `rx_valid`.
  - On reaching `TIMEOUT_CYCLES`: `byte_count`←0, counter←0, `timeout_err` pulses.
  - `rx_valid` in the expiry cycle wins: the byte is accepted and there is no timeout.
  - The counter is idle in HOLD and with `byte_count`=0.
- Not defined: no counter logic; partial blocks persist until completed or reset; `timeout_err` is tied 0.

## Structure
- Shared package `aes_uart_pkg`: `BLOCK_BYTES`, `BLOCK_W`=128, packer state enum (FILL, HOLD). These are shared with the downstream AES wrapper and the TX serializer.
- Sub-module `packer_idle_timer` (counter, clear, enable, expiry pulse). It is instantiated only under `PACKER_TIMEOUT_EN`.

## Test plan
- Strobe bytes 0x00,0x11,…,0xff with `block_ready`=1 → `block_valid` after 16th strobe, `block_out`=128'h00112233445566778899aabbccddeeff, accepted the same cycle, `byte_count`=0.
- Fill a block with `block_ready`=0 for 20 cycles, strobe 0xAA during HOLD → `block_out` unchanged, `overrun` one-cycle pulse, `byte_count` stays 16. Raise ready → `block_valid` drops.
- In HOLD, assert `block_ready` and strobe 0x5C the same cycle → handshake done, no overrun, `byte_count`=1. The next block's MSB byte is 0x5C.
- With `PACKER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100: send 5 bytes then idle 100 cycles → `timeout_err` pulse, `byte_count`=0. The next 16 bytes 0x01..0x10 give 128'h0102030405060708090a0b0c0d0e0f10.
- Send 7 bytes, assert `rst` asynchronously mid-cycle → `byte_count`=0, `block_valid`=0 immediately. After release, a full 16 bytes produces a correct block.
- Without `PACKER_TIMEOUT_EN`: 5 bytes, idle 10 000 cycles, 11 more bytes → single correct block, `timeout_err` never asserted.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// rtl/aes_uart_pkg.sv - shared AES-over-UART constants and packer state type
package aes_uart_pkg;
  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 8 * BLOCK_BYTES;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;
endpackage

// File: rtl/packer_idle_timer.sv
// rtl/packer_idle_timer.sv - inter-byte idle counter with one-cycle expiry indication
module packer_idle_timer #(
  parameter int LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  // Expiry fires on the LIMIT-th consecutive enabled cycle; a clear in that cycle wins.
  assign expired = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || expired) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/uart_block_packer.sv
// rtl/uart_block_packer.sv - packs UART bytes MSB-first into a block held under valid/ready
// Optional idle-timeout abort of partial blocks: define PACKER_TIMEOUT_EN.
module uart_block_packer
  import aes_uart_pkg::*;
#(
  parameter int BLOCK_BYTES    = aes_uart_pkg::BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         rx_data,
  input  logic                               rx_valid,
  output logic [8*BLOCK_BYTES-1:0]           block_out,
  output logic                               block_valid,
  input  logic                               block_ready,
  output logic [$clog2(BLOCK_BYTES+1)-1:0]   byte_count,
  output logic                               overrun,
  output logic                               timeout_err
);
  localparam int BW = 8 * BLOCK_BYTES;
  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_BYTES - 1);

  packer_state_e state_q, state_d;
  logic [BW-1:0] block_d;
  logic [CW-1:0] count_d;
  logic          overrun_d;
  logic          fire;
  logic          take;
  logic          expire;

  // A byte arriving in the handshake cycle becomes byte 0 of the next block.
  assign fire = (state_q == HOLD) && block_ready;
  assign take = rx_valid && ((state_q == FILL) || fire);
  assign block_valid = (state_q == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (take && (byte_count == LAST_IDX)) state_d = HOLD;
      HOLD:    if (block_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    block_d   = block_out;
    count_d   = byte_count;
    overrun_d = 1'b0;
    if (take) block_d = {block_out[BW-9:0], rx_data};
    case (state_q)
      FILL: begin
        if (take)        count_d = byte_count + 1'b1;
        else if (expire) count_d = '0;
      end
      HOLD: begin
        if (fire)          count_d = take ? CW'(1) : '0;
        else if (rx_valid) overrun_d = 1'b1;
      end
      default: count_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_out  <= '0;
      byte_count <= '0;
      overrun    <= 1'b0;
    end else begin
      block_out  <= block_d;
      byte_count <= count_d;
      overrun    <= overrun_d;
    end
  end

`ifdef PACKER_TIMEOUT_EN
  logic timer_en;
  logic timeout_q;

  assign timer_en = (state_q == FILL) && (byte_count != '0) && !rx_valid;

  packer_idle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (rx_valid),
    .enable  (timer_en),
    .expired (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= expire;
  end
  assign timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < 2);
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_block_packer.sv
// tb/tb_uart_block_packer.sv - table-driven and directed checks for uart_block_packer
module tb_uart_block_packer;
  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic [4:0]   byte_count;
  logic         overrun;
  logic         timeout_err;

  int n_vec = 0;
  int n_err = 0;
  bit tout_seen = 1'b0;

  typedef struct {
    logic         v;
    logic [7:0]   d;
    logic         r;
    logic         ev;
    logic [4:0]   ec;
    logic         eo;
    logic         cb;
    logic [127:0] eb;
  } vec_t;

  vec_t tbl[$];

  localparam logic [127:0] EXP_A   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP_B   = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
  localparam logic [127:0] EXP_SEQ = 128'h0102030405060708090a0b0c0d0e0f10;
  localparam logic [127:0] EXP_5C  = 128'h5c0102030405060708090a0b0c0d0e0f;

  uart_block_packer #(
    .BLOCK_BYTES    (16),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .byte_count  (byte_count),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    rx_valid    = v;
    rx_data     = d;
    block_ready = r;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    if (timeout_err) tout_seen = 1'b1;
  endtask

  task automatic send_seq(input logic [7:0] first, input int n, input logic r);
    for (int k = 0; k < n; k++) step(1'b1, first + 8'(k), r);
  endtask

  function automatic void add(input logic v, input logic [7:0] d, input logic r, input logic ev,
                              input logic [4:0] ec, input logic eo, input logic cb,
                              input logic [127:0] eb);
    tbl.push_back('{v, d, r, ev, ec, eo, cb, eb});
  endfunction

  initial begin
    // Full block with ready held high, then a held block with overrun.
    for (int i = 0; i < 16; i++)
      add(1'b1, 8'(i * 17), 1'b1, i == 15, (i == 15) ? 5'd16 : 5'(i + 1), 1'b0, i == 15, EXP_A);
    add(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++)
      add(1'b1, 8'hA0 + 8'(i), 1'b0, i == 15, (i == 15) ? 5'd16 : 5'(i + 1), 1'b0, i == 15, EXP_B);
    for (int i = 0; i < 20; i++)
      add(1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b0, 1'b1, EXP_B);
    add(1'b1, 8'hAA, 1'b0, 1'b1, 5'd16, 1'b1, 1'b1, EXP_B);
    add(1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b0, 1'b1, EXP_B);
    add(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, '0);

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    block_ready = 1'b0;
    @(negedge clk);
    check("reset_block_out", block_out, '0);
    check("reset_valid", 128'(block_valid), 128'(0));
    check("reset_count", 128'(byte_count), 128'(0));
    check("reset_overrun", 128'(overrun), 128'(0));
    check("reset_timeout", 128'(timeout_err), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r);
      check($sformatf("vec%0d_valid", i), 128'(block_valid), 128'(tbl[i].ev));
      check($sformatf("vec%0d_count", i), 128'(byte_count), 128'(tbl[i].ec));
      check($sformatf("vec%0d_overrun", i), 128'(overrun), 128'(tbl[i].eo));
      if (tbl[i].cb) check($sformatf("vec%0d_block", i), block_out, tbl[i].eb);
    end

    // Byte arriving in the handshake cycle starts the next block.
    send_seq(8'h30, 16, 1'b0);
    check("same_cycle_pre_valid", 128'(block_valid), 128'(1));
    step(1'b1, 8'h5C, 1'b1);
    check("same_cycle_valid", 128'(block_valid), 128'(0));
    check("same_cycle_count", 128'(byte_count), 128'(1));
    check("same_cycle_overrun", 128'(overrun), 128'(0));
    send_seq(8'h01, 15, 1'b0);
    check("same_cycle_next_valid", 128'(block_valid), 128'(1));
    check("same_cycle_next_block", block_out, EXP_5C);
    check("same_cycle_next_overrun", 128'(overrun), 128'(0));
    step(1'b0, 8'h00, 1'b1);
    check("same_cycle_drain", 128'(block_valid), 128'(0));

    // Asynchronous reset in the middle of a cycle discards a partial block.
    send_seq(8'h70, 7, 1'b0);
    check("pre_reset_count", 128'(byte_count), 128'(7));
    #2 rst = 1'b1;
    #1;
    check("async_reset_count", 128'(byte_count), 128'(0));
    check("async_reset_valid", 128'(block_valid), 128'(0));
    check("async_reset_block", block_out, '0);
    @(negedge clk);
    rst = 1'b0;
    send_seq(8'h01, 16, 1'b0);
    check("post_reset_valid", 128'(block_valid), 128'(1));
    check("post_reset_block", block_out, EXP_SEQ);
    step(1'b0, 8'h00, 1'b1);
    check("post_reset_drain", 128'(block_valid), 128'(0));

`ifdef PACKER_TIMEOUT_EN
    tout_seen = 1'b0;
    send_seq(8'h01, 5, 1'b0);
    for (int k = 0; k < 99; k++) step(1'b0, 8'h00, 1'b0);
    check("timeout_not_yet", 128'(tout_seen), 128'(0));
    check("timeout_count_kept", 128'(byte_count), 128'(5));
    step(1'b0, 8'h00, 1'b0);
    check("timeout_pulse", 128'(timeout_err), 128'(1));
    check("timeout_count_clr", 128'(byte_count), 128'(0));
    step(1'b0, 8'h00, 1'b0);
    check("timeout_pulse_end", 128'(timeout_err), 128'(0));
    send_seq(8'h01, 16, 1'b0);
    check("timeout_next_block", block_out, EXP_SEQ);
    check("timeout_next_valid", 128'(block_valid), 128'(1));
    step(1'b0, 8'h00, 1'b1);

    tout_seen = 1'b0;
    send_seq(8'h01, 5, 1'b0);
    for (int k = 0; k < 99; k++) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h06, 1'b0);
    check("expiry_byte_wins_count", 128'(byte_count), 128'(6));
    step(1'b0, 8'h00, 1'b0);
    check("expiry_byte_wins_tout", 128'(tout_seen), 128'(0));
`else
    tout_seen = 1'b0;
    send_seq(8'h01, 5, 1'b0);
    for (int k = 0; k < 10000; k++) step(1'b0, 8'h00, 1'b0);
    check("idle_count_kept", 128'(byte_count), 128'(5));
    send_seq(8'h06, 11, 1'b0);
    check("idle_block_valid", 128'(block_valid), 128'(1));
    check("idle_block", block_out, EXP_SEQ);
    check("timeout_never", 128'(tout_seen), 128'(0));
    step(1'b0, 8'h00, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
